// File: rtl/hv_hamming_classifier.sv
// Associative-memory stage: streams the latched query against every class
// prototype CHUNK bits per cycle and reports per-class Hamming distance plus argmin.
module hv_hamming_classifier #(
  parameter int DIMENSIONS  = 10000,
  parameter int NUM_CLASSES = 2,
  parameter int CHUNK       = 100,
  localparam int DW  = $clog2(DIMENSIONS + 1),
  localparam int CIW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic [DIMENSIONS-1:0] hv_in,
  input  logic [DIMENSIONS-1:0] class_hvs [NUM_CLASSES],
  output logic                  out,
  output logic [CIW-1:0]        class_out,
  output logic [DW-1:0]         dist_out  [NUM_CLASSES]
);

  localparam int NUM_CHUNKS = DIMENSIONS / CHUNK;
  localparam int CW         = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int PW         = $clog2(CHUNK + 1);
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NUM_CHUNKS - 1);

  generate
    if (DIMENSIONS % CHUNK != 0) begin : g_bad_chunk
      $error("hv_hamming_classifier: DIMENSIONS must be a multiple of CHUNK");
    end
    if (NUM_CLASSES < 2) begin : g_bad_classes
      $error("hv_hamming_classifier: NUM_CLASSES must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ACCUM, COMPARE} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         chunk_idx;
  logic [DIMENSIONS-1:0] query;
  logic [DW-1:0]         acc       [NUM_CLASSES];
  logic [CHUNK-1:0]      diff      [NUM_CLASSES];
  logic [PW-1:0]         chunk_pop [NUM_CLASSES];
  logic [CIW-1:0]        best_idx;
  logic [DW-1:0]         best_dist;
  logic                  last_chunk;

  assign last_chunk = (chunk_idx == LAST_CHUNK);
  // Idle doubles as "result valid", so out needs no register of its own.
  assign out        = (state == IDLE);

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path
  // through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = ACCUM;
      ACCUM:   if (last_chunk) state_nxt = COMPARE;
      COMPARE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    for (int c = 0; c < NUM_CLASSES; c++) begin
      diff[c] = query[int'(chunk_idx) * CHUNK +: CHUNK]
              ^ class_hvs[c][int'(chunk_idx) * CHUNK +: CHUNK];
      chunk_pop[c] = '0;
      for (int i = 0; i < CHUNK; i++) begin
        chunk_pop[c] = chunk_pop[c] + PW'(diff[c][i]);
      end
    end
  end

  // Strict less-than scan from index 0: ties resolve to the lowest index.
  always_comb begin
    best_idx  = '0;
    best_dist = acc[0];
    for (int c = 1; c < NUM_CLASSES; c++) begin
      if (acc[c] < best_dist) begin
        best_dist = acc[c];
        best_idx  = CIW'(c);
      end
    end
  end

  // NOTE: the query register is wide but still reset; only the hold-stable
  // class prototypes live outside this block.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      query     <= '0;
      chunk_idx <= '0;
      class_out <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        acc[c]      <= '0;
        dist_out[c] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            query     <= hv_in;
            chunk_idx <= '0;
            for (int c = 0; c < NUM_CLASSES; c++) acc[c] <= '0;
          end
        end
        ACCUM: begin
          for (int c = 0; c < NUM_CLASSES; c++) acc[c] <= acc[c] + DW'(chunk_pop[c]);
          chunk_idx <= last_chunk ? '0 : chunk_idx + 1'b1;
        end
        COMPARE: begin
          for (int c = 0; c < NUM_CLASSES; c++) dist_out[c] <= acc[c];
          class_out <= best_idx;
        end
        default: ;
      endcase
    end
  end

endmodule
